mcu_seq: RTL and testbench

- Next-generation parametrised MCU datapath: instruction port with valid/ready handshake, internal register-file memory, sequenced ALU with iterative multiply/divide.
- Adds shifts, divide-by-zero/illegal-op detection, and one-instruction-in-flight flow control.
- Sits between the instruction source and downstream result consumer; replaces the single-cycle combinational-control MCU.

---
 rtl/mcu_pkg.sv | 39 +++
 rtl/mcu_muldiv.sv | 89 ++++++++
 rtl/memory.sv | 27 ++
 rtl/mcu_seq.sv | 170 +++++++++++++++++
 tb/tb_mcu_seq.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mcu_pkg.sv
// Shared opcode, FSM and iterative-unit definitions for the sequenced MCU datapath.
package mcu_pkg;

    localparam int OP_W = 4;

    localparam logic [OP_W-1:0] OP_ADD = 4'd0;
    localparam logic [OP_W-1:0] OP_SUB = 4'd1;
    localparam logic [OP_W-1:0] OP_MUL = 4'd2;
    localparam logic [OP_W-1:0] OP_DIV = 4'd3;
    localparam logic [OP_W-1:0] OP_OR  = 4'd4;
    localparam logic [OP_W-1:0] OP_AND = 4'd5;
    localparam logic [OP_W-1:0] OP_XOR = 4'd6;
    localparam logic [OP_W-1:0] OP_RD  = 4'd7;
    localparam logic [OP_W-1:0] OP_WR  = 4'd8;
    localparam logic [OP_W-1:0] OP_SHL = 4'd9;
    localparam logic [OP_W-1:0] OP_SHR = 4'd10;
    localparam logic [OP_W-1:0] OP_SRA = 4'd11;
    localparam logic [OP_W-1:0] ILLEGAL_MIN = 4'd12;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2
    } state_t;

    typedef enum logic {
        MD_MUL = 1'b0,
        MD_DIV = 1'b1
    } md_mode_t;

    function automatic logic is_muldiv(input logic [OP_W-1:0] opc);
        return (opc == OP_MUL) || (opc == OP_DIV);
    endfunction

    function automatic logic is_illegal(input logic [OP_W-1:0] opc);
        return opc >= ILLEGAL_MIN;
    endfunction

endpackage

// File: rtl/mcu_muldiv.sv
// Iterative unit: MSB-first shift-add multiplier and restoring divider, DATA_W steps each.
module mcu_muldiv
    import mcu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  md_mode_t          mode,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              div0
);

    localparam int CNT_W = $clog2(DATA_W) + 1;

    logic              busy_reg;
    md_mode_t          mode_reg;
    logic [DATA_W-1:0] acc_reg;
    logic [DATA_W-1:0] x_reg;
    logic [DATA_W-1:0] b_reg;
    logic [CNT_W-1:0]  cnt_reg;

    logic [DATA_W-1:0] cur_acc, cur_x, cur_b;
    md_mode_t          cur_mode;
    logic [DATA_W-1:0] acc_next, x_next;
    logic [DATA_W:0]   rem_sh, rem_diff;

    // The start edge performs the first step on the raw operands, so the
    // whole operation fits in exactly DATA_W clock edges.
    always_comb begin
        cur_acc  = start ? '0 : acc_reg;
        cur_x    = start ? a : x_reg;
        cur_b    = start ? b : b_reg;
        cur_mode = start ? mode : mode_reg;
        rem_sh   = {cur_acc, cur_x[DATA_W-1]};
        rem_diff = rem_sh - {1'b0, cur_b};
        acc_next = '0;
        x_next   = '0;
        if (cur_mode == MD_MUL) begin
            acc_next = (cur_acc << 1) + (cur_x[DATA_W-1] ? cur_b : '0);
            x_next   = cur_x << 1;
        end else if (rem_sh >= {1'b0, cur_b}) begin
            acc_next = rem_diff[DATA_W-1:0];
            x_next   = {cur_x[DATA_W-2:0], 1'b1};
        end else begin
            acc_next = rem_sh[DATA_W-1:0];
            x_next   = {cur_x[DATA_W-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_reg <= 1'b0;
            mode_reg <= MD_MUL;
            acc_reg  <= '0;
            x_reg    <= '0;
            b_reg    <= '0;
            cnt_reg  <= '0;
        end else begin
            if (start) begin
                busy_reg <= 1'b1;
                cnt_reg  <= CNT_W'(1);
                mode_reg <= mode;
                b_reg    <= b;
            end else if (busy_reg) begin
                cnt_reg <= cnt_reg + CNT_W'(1);
                if (done) begin
                    busy_reg <= 1'b0;
                end
            end
            if (start || busy_reg) begin
                acc_reg <= acc_next;
                x_reg   <= x_next;
            end
        end
    end

    // done marks the cycle whose closing edge performs the final step.
    assign busy   = busy_reg;
    assign done   = busy_reg && (cnt_reg == CNT_W'(DATA_W - 1));
    assign result = (mode_reg == MD_DIV) ? x_reg : acc_reg;
    assign div0   = (b_reg == '0);

endmodule

// File: rtl/memory.sv
// Register-file memory: two combinational read ports, one synchronous write port.
module memory #(
    parameter int Addr_width = 8,
    parameter int data_width = 32
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [Addr_width-1:0] waddr,
    input  logic [data_width-1:0] wdata,
    input  logic [Addr_width-1:0] raddr0,
    output logic [data_width-1:0] rdata0,
    input  logic [Addr_width-1:0] raddr1,
    output logic [data_width-1:0] rdata1
);

    logic [data_width-1:0] mem_reg [2**Addr_width];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_reg[waddr] <= wdata;
        end
    end

    assign rdata0 = mem_reg[raddr0];
    assign rdata1 = mem_reg[raddr1];

endmodule

// File: rtl/mcu_seq.sv
// Sequenced MCU datapath: one instruction in flight, IDLE/EXEC/WB control, iterative mul/div.
module mcu_seq
    import mcu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   op,
    input  logic [ADDR_W-1:0] op0,
    input  logic [DATA_W-1:0] op1,
    input  logic [ADDR_W-1:0] op2,
    output logic [DATA_W-1:0] out,
    output logic              op_done,
    output logic              op_err
);

    localparam int SH_W = $clog2(DATA_W);

    state_t            state_reg, state_next;
    logic [OP_W-1:0]   op_reg;
    logic [ADDR_W-1:0] op0_reg, op2_reg;
    logic [DATA_W-1:0] op1_reg;
    logic [DATA_W-1:0] out_reg, out_next;
    logic              op_done_reg, op_done_next;
    logic              op_err_reg, op_err_next;
    logic              in_ready_reg, in_ready_next;

    logic              accept;
    logic [DATA_W-1:0] a_word, b_word, alu_result;
    logic [SH_W-1:0]   sh_amt;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    logic              md_start, md_busy, md_done, md_div0;
    logic [DATA_W-1:0] md_result;
    md_mode_t          md_mode;

    assign accept = in_valid && in_ready_reg;
    assign sh_amt = b_word[SH_W-1:0];
    assign md_mode = (op_reg == OP_DIV) ? MD_DIV : MD_MUL;

    memory #(
        .Addr_width(ADDR_W),
        .data_width(DATA_W)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .raddr0(op0_reg),
        .rdata0(a_word),
        .raddr1(op1_reg[ADDR_W-1:0]),
        .rdata1(b_word)
    );

    mcu_muldiv #(
        .DATA_W(DATA_W)
    ) u_muldiv (
        .clk   (clk),
        .reset (reset),
        .start (md_start),
        .mode  (md_mode),
        .a     (a_word),
        .b     (b_word),
        .busy  (md_busy),
        .done  (md_done),
        .result(md_result),
        .div0  (md_div0)
    );

    always_comb begin
        alu_result = '0;
        case (op_reg)
            OP_ADD:         alu_result = a_word + b_word;
            OP_SUB:         alu_result = a_word - b_word;
            OP_MUL, OP_DIV: alu_result = md_result;
            OP_OR:          alu_result = a_word | b_word;
            OP_AND:         alu_result = a_word & b_word;
            OP_XOR:         alu_result = a_word ^ b_word;
            OP_SHL:         alu_result = a_word << sh_amt;
            OP_SHR:         alu_result = a_word >> sh_amt;
            OP_SRA:         alu_result = $signed(a_word) >>> sh_amt;
            default:        alu_result = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= S_IDLE;
            out_reg      <= '0;
            op_done_reg  <= 1'b0;
            op_err_reg   <= 1'b0;
            in_ready_reg <= 1'b0;
            op_reg       <= '0;
            op0_reg      <= '0;
            op1_reg      <= '0;
            op2_reg      <= '0;
        end else begin
            state_reg    <= state_next;
            out_reg      <= out_next;
            op_done_reg  <= op_done_next;
            op_err_reg   <= op_err_next;
            in_ready_reg <= in_ready_next;
            if (accept) begin
                op_reg  <= op;
                op0_reg <= op0;
                op1_reg <= op1;
                op2_reg <= op2;
            end
        end
    end

    // WB actions (write-back, out, op_done) all land on the edge leaving WB.
    always_comb begin
        state_next   = state_reg;
        out_next     = out_reg;
        op_done_next = 1'b0;
        op_err_next  = 1'b0;
        mem_we       = 1'b0;
        mem_waddr    = op2_reg;
        mem_wdata    = alu_result;
        md_start     = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (accept) begin
                    state_next = is_illegal(op) ? S_WB : S_EXEC;
                end
            end
            S_EXEC: begin
                if (is_muldiv(op_reg)) begin
                    md_start = !md_busy;
                    if (md_done) begin
                        state_next = S_WB;
                    end
                end else begin
                    state_next = S_WB;
                end
            end
            S_WB: begin
                state_next   = S_IDLE;
                op_done_next = 1'b1;
                if (is_illegal(op_reg) || (op_reg == OP_DIV && md_div0)) begin
                    op_err_next = 1'b1;
                end else if (op_reg == OP_RD) begin
                    out_next = a_word;
                end else if (op_reg == OP_WR) begin
                    mem_we    = 1'b1;
                    mem_waddr = op0_reg;
                    mem_wdata = op1_reg;
                    out_next  = op1_reg;
                end else begin
                    mem_we = 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase
        in_ready_next = (state_next == S_IDLE);
    end

    assign in_ready = in_ready_reg;
    assign out      = out_reg;
    assign op_done  = op_done_reg;
    assign op_err   = op_err_reg;

endmodule

// File: tb/tb_mcu_seq.sv
// Bench for mcu_seq: vector table plus hand-written sequences, completions checked from a scoreboard.
module tb_mcu_seq;

    localparam int DW = 32;
    localparam int AW = 8;
    localparam int LAT1 = 2;
    localparam int LATMD = 1 + DW;
    localparam int LATILL = 1;

    localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, MUL = 4'd2, DIV = 4'd3;
    localparam logic [3:0] LOR = 4'd4, LAND = 4'd5, LXOR = 4'd6, RD = 4'd7;
    localparam logic [3:0] WR = 4'd8, SHL = 4'd9, SHR = 4'd10, SRA = 4'd11;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [3:0]    op = '0;
    logic [AW-1:0] op0 = '0;
    logic [DW-1:0] op1 = '0;
    logic [AW-1:0] op2 = '0;
    logic [DW-1:0] out;
    logic          op_done;
    logic          op_err;

    mcu_seq #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk     (clk),
        .reset   (reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .op      (op),
        .op0     (op0),
        .op1     (op1),
        .op2     (op2),
        .out     (out),
        .op_done (op_done),
        .op_err  (op_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]    op;
        logic [AW-1:0] op0;
        logic [DW-1:0] op1;
        logic [AW-1:0] op2;
        logic [DW-1:0] exp_out;
        logic          exp_err;
        int            lat;
    } vec_t;

    typedef struct {
        int            id;
        logic [DW-1:0] exp_out;
        logic          exp_err;
        int            done_cyc;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   ready_while_busy = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(string nm, int id, logic [DW-1:0] act, logic [DW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s id=%0d actual=0x%08h required=0x%08h", nm, id, act, exp);
    endfunction

    function automatic void add_vec(logic [3:0] o, logic [AW-1:0] a0, logic [DW-1:0] a1,
                                    logic [AW-1:0] a2, logic [DW-1:0] eo, logic ee, int lat);
        vec_t v;
        v.op = o; v.op0 = a0; v.op1 = a1; v.op2 = a2;
        v.exp_out = eo; v.exp_err = ee; v.lat = lat;
        vecs.push_back(v);
    endfunction

    // Completion monitor: every op_done must match the oldest pending expectation.
    always @(negedge clk) begin
        if (reset) begin
            if (op_done) begin
                if (sb.size() == 0) begin
                    check("spurious_op_done", -1, 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("out", e.id, out, e.exp_out);
                    check("op_err", e.id, {31'd0, op_err}, {31'd0, e.exp_err});
                    check("latency", e.id, cyc, e.done_cyc);
                    $display("txn %0d done at cycle %0d out=0x%08h err=%0b", e.id, cyc, out, op_err);
                end
            end else if (sb.size() != 0 && in_ready) begin
                ready_while_busy++;
            end
        end
    end

    task automatic issue(input logic [3:0] o, input logic [AW-1:0] a0, input logic [DW-1:0] a1,
                         input logic [AW-1:0] a2, input logic [DW-1:0] eo, input logic ee,
                         input int lat, input int id, input bit hold);
        int   waited = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            if (in_valid) begin
                op  = 4'($urandom);
                op0 = AW'($urandom);
                op1 = $urandom;
                op2 = AW'($urandom);
            end
            waited++;
            if (waited > 200) begin
                check("ready_timeout", id, 32'd0, 32'd1);
                return;
            end
        end
        op = o; op0 = a0; op1 = a1; op2 = a2;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        e.id = id; e.exp_out = eo; e.exp_err = ee; e.done_cyc = cyc + lat;
        sb.push_back(e);
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic drain(input int id);
        int waited = 0;
        while (sb.size() != 0 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (sb.size() != 0) check("drain_timeout", id, 32'd0, 32'd1);
    endtask

    initial begin
        int id;
        logic [DW-1:0] val;

        add_vec(WR, 5, 32'h0000_00AA, 0, 32'h0000_00AA, 0, LAT1);
        add_vec(RD, 5, 0, 0, 32'h0000_00AA, 0, LAT1);
        add_vec(WR, 1, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFF, 0, LAT1);
        add_vec(WR, 2, 32'd2, 0, 32'd2, 0, LAT1);
        add_vec(ADD, 1, 2, 3, 32'd2, 0, LAT1);
        add_vec(RD, 3, 0, 0, 32'd1, 0, LAT1);
        add_vec(SUB, 2, 1, 7, 32'd1, 0, LAT1);
        add_vec(RD, 7, 0, 0, 32'd3, 0, LAT1);
        add_vec(WR, 1, 32'd100, 0, 32'd100, 0, LAT1);
        add_vec(WR, 2, 32'd7, 0, 32'd7, 0, LAT1);
        add_vec(DIV, 1, 2, 4, 32'd7, 0, LATMD);
        add_vec(RD, 4, 0, 0, 32'd14, 0, LAT1);
        add_vec(WR, 8, 32'h0001_0000, 0, 32'h0001_0000, 0, LAT1);
        add_vec(MUL, 8, 8, 9, 32'h0001_0000, 0, LATMD);
        add_vec(RD, 9, 0, 0, 32'd0, 0, LAT1);
        add_vec(WR, 10, 32'd12345, 0, 32'd12345, 0, LAT1);
        add_vec(WR, 11, 32'd1000, 0, 32'd1000, 0, LAT1);
        add_vec(MUL, 10, 11, 12, 32'd1000, 0, LATMD);
        add_vec(DIV, 10, 11, 13, 32'd1000, 0, LATMD);
        add_vec(RD, 12, 0, 0, 32'd12345000, 0, LAT1);
        add_vec(RD, 13, 0, 0, 32'd12, 0, LAT1);
        add_vec(WR, 20, 32'hF0F0_1234, 0, 32'hF0F0_1234, 0, LAT1);
        add_vec(WR, 21, 32'h0FF0_FF00, 0, 32'h0FF0_FF00, 0, LAT1);
        add_vec(LOR, 20, 21, 22, 32'h0FF0_FF00, 0, LAT1);
        add_vec(LAND, 20, 21, 23, 32'h0FF0_FF00, 0, LAT1);
        add_vec(LXOR, 20, 21, 24, 32'h0FF0_FF00, 0, LAT1);
        add_vec(RD, 22, 0, 0, 32'hFFF0_FF34, 0, LAT1);
        add_vec(RD, 23, 0, 0, 32'h00F0_1200, 0, LAT1);
        add_vec(RD, 24, 0, 0, 32'hFF00_ED34, 0, LAT1);
        add_vec(WR, 2, 32'd0, 0, 32'd0, 0, LAT1);
        add_vec(WR, 6, 32'h5555, 0, 32'h5555, 0, LAT1);
        add_vec(DIV, 1, 2, 6, 32'h5555, 1, LATMD);
        add_vec(RD, 6, 0, 0, 32'h5555, 0, LAT1);
        add_vec(4'd13, 1, 2, 6, 32'h5555, 1, LATILL);
        add_vec(WR, 1, 32'h8000_0000, 0, 32'h8000_0000, 0, LAT1);
        add_vec(WR, 2, 32'd4, 0, 32'd4, 0, LAT1);
        add_vec(SRA, 1, 2, 30, 32'd4, 0, LAT1);
        add_vec(SHR, 1, 2, 31, 32'd4, 0, LAT1);
        add_vec(RD, 30, 0, 0, 32'hF800_0000, 0, LAT1);
        add_vec(RD, 31, 0, 0, 32'h0800_0000, 0, LAT1);
        add_vec(WR, 2, 32'd33, 0, 32'd33, 0, LAT1);
        add_vec(SHL, 1, 2, 32, 32'd33, 0, LAT1);
        add_vec(WR, 3, 32'd1, 0, 32'd1, 0, LAT1);
        add_vec(SHL, 3, 2, 33, 32'd1, 0, LAT1);
        add_vec(RD, 32, 0, 0, 32'd0, 0, LAT1);
        add_vec(RD, 33, 0, 0, 32'd2, 0, LAT1);
        add_vec(ADD, 33, 33, 33, 32'd2, 0, LAT1);
        add_vec(RD, 33, 0, 0, 32'd4, 0, LAT1);
        add_vec(4'd15, 0, 0, 0, 32'd4, 1, LATILL);

        // Reset for three cycles, then ready on the first cycle after release.
        repeat (3) @(negedge clk);
        check("rst_in_ready", 0, {31'd0, in_ready}, 32'd0);
        check("rst_out", 0, out, 32'd0);
        check("rst_op_done", 0, {31'd0, op_done}, 32'd0);
        check("rst_op_err", 0, {31'd0, op_err}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("ready_after_rst", 0, {31'd0, in_ready}, 32'd1);

        for (int i = 0; i < vecs.size(); i++) begin
            issue(vecs[i].op, vecs[i].op0, vecs[i].op1, vecs[i].op2,
                  vecs[i].exp_out, vecs[i].exp_err, vecs[i].lat, i, 1'b0);
        end
        drain(100);
        check("ready_while_busy", 100, ready_while_busy, 32'd0);

        // Dependent add chain with in_valid held high throughout.
        issue(WR, 40, 32'd1, 0, 32'd1, 0, LAT1, 200, 1'b1);
        issue(WR, 50, 32'd3, 0, 32'd3, 0, LAT1, 201, 1'b1);
        for (int i = 0; i < 5; i++) begin
            issue(ADD, AW'(40 + i), 50, AW'(41 + i), 32'd3, 0, LAT1, 210 + i, 1'b1);
        end
        val = 32'd1;
        for (int i = 0; i < 5; i++) begin
            val = val + 32'd3;
            issue(RD, AW'(41 + i), 0, 0, val, 0, LAT1, 220 + i, (i != 4));
        end
        drain(230);

        // Reset during a multiply: no completion, destination untouched, out cleared.
        issue(WR, 60, 32'h1234, 0, 32'h1234, 0, LAT1, 300, 1'b0);
        issue(WR, 61, 32'd5, 0, 32'd5, 0, LAT1, 301, 1'b0);
        issue(WR, 62, 32'hDEAD, 0, 32'hDEAD, 0, LAT1, 302, 1'b0);
        issue(MUL, 60, 61, 62, 32'hDEAD, 0, LATMD, 303, 1'b0);
        repeat (9) @(negedge clk);
        reset = 1'b0;
        sb.delete();
        #1;
        check("abort_out", 303, out, 32'd0);
        check("abort_op_done", 303, {31'd0, op_done}, 32'd0);
        repeat (2) @(negedge clk);
        check("abort_in_ready", 303, {31'd0, in_ready}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("abort_ready_after", 303, {31'd0, in_ready}, 32'd1);
        repeat (40) @(negedge clk);
        check("abort_no_done", 303, {31'd0, op_done}, 32'd0);
        issue(RD, 62, 0, 0, 32'hDEAD, 0, LAT1, 304, 1'b0);
        drain(305);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
